// File: rtl/mult_rs_pkg.sv
// Shared types for the multiply reservation-station controller.
// Optional feature macro: MULT_RS_AGE_SELECT_EN (oldest-first issue selection).
package mult_rs_pkg;

  // Tag width baked into the entry and issue structs; the top-level TAG_W
  // parameter defaults to this value and should be kept equal to it.
  localparam int DEFAULT_TAG_W = 6;

  // One reservation-station slot.
  typedef struct packed {
    logic                     valid;
    logic [31:0]              op1;
    logic [31:0]              op2;
    logic                     op1Rdy;
    logic                     op2Rdy;
    logic [DEFAULT_TAG_W-1:0] op1Tag;
    logic [DEFAULT_TAG_W-1:0] op2Tag;
    logic [2:0]               funct3;
    logic [DEFAULT_TAG_W-1:0] tag;
  } mult_rs_entry_t;

  // Contents of the registered issue slot seen by the multiplier.
  typedef struct packed {
    logic                     en;
    logic                     tagValid;
    logic [31:0]              op1;
    logic [31:0]              op2;
    logic [2:0]               funct3;
    logic [DEFAULT_TAG_W-1:0] tag;
  } issue_pkt_t;

  // Converts a selected entry into an active issue packet.
  function automatic issue_pkt_t issueFromEntry(input mult_rs_entry_t e);
    issue_pkt_t p;
    p.en       = e.valid;
    p.tagValid = e.valid;
    p.op1      = e.op1;
    p.op2      = e.op2;
    p.funct3   = e.funct3;
    p.tag      = e.tag;
    return p;
  endfunction

endpackage

// File: rtl/mult_rs_select.sv
// Issue selector: picks one ready entry and returns a one-hot grant.
// With MULT_RS_AGE_SELECT_EN the ready entry with the smallest age rank
// (the oldest) wins; otherwise the lowest-index ready entry wins.
module mult_rs_select #(
  parameter int ENTRIES = 4
`ifdef MULT_RS_AGE_SELECT_EN
  ,
  parameter int RANK_W  = 2
`endif
) (
  input  logic [ENTRIES-1:0]             ready_i,
`ifdef MULT_RS_AGE_SELECT_EN
  input  logic [ENTRIES-1:0][RANK_W-1:0] age_i,
`endif
  output logic [ENTRIES-1:0]             grant_o,
  output logic                           valid_o
);

`ifdef MULT_RS_AGE_SELECT_EN
  // Scan all ready entries keeping the one with the smallest rank.
  always_comb begin
    logic              found;
    logic [RANK_W-1:0] bestAge;
    found   = 1'b0;
    bestAge = '0;
    grant_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_i[i] && (!found || (age_i[i] < bestAge))) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        bestAge    = age_i[i];
        found      = 1'b1;
      end
    end
    valid_o = found;
  end
`else
  // Fixed priority: the first ready entry from index 0 upward wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end
`endif

endmodule

// File: rtl/mult_rs_ctrl.sv
// Reservation-station controller and issue scheduler for the 3-stage
// pipelined multiplier. Holds dispatched MUL/MULH ops until both operands
// are known (snooping the CDB), issues one per cycle into a registered issue
// slot, and throttles issue with a credit count of free result-buffer slots.
// Optional feature macro: MULT_RS_AGE_SELECT_EN (oldest-first selection).
module mult_rs_ctrl
  import mult_rs_pkg::*;
#(
  parameter int ENTRIES     = 4,
  parameter int RES_CREDITS = 4,
  parameter int TAG_W       = DEFAULT_TAG_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [31:0]                      disp_op1,
  input  logic [31:0]                      disp_op2,
  input  logic                             disp_op1_rdy,
  input  logic                             disp_op2_rdy,
  input  logic [TAG_W-1:0]                 disp_op1_tag,
  input  logic [TAG_W-1:0]                 disp_op2_tag,
  input  logic [2:0]                       disp_funct3,
  input  logic [TAG_W-1:0]                 disp_tag,
  input  logic                             cdb_valid,
  input  logic [TAG_W-1:0]                 cdb_tag,
  input  logic [31:0]                      cdb_data,
  output logic                             issue_en,
  output logic [31:0]                      issue_op1,
  output logic [31:0]                      issue_op2,
  output logic [2:0]                       issue_funct3,
  output logic [TAG_W-1:0]                 issue_tag,
  output logic                             issue_tag_valid,
  input  logic                             res_pop,
  output logic [$clog2(RES_CREDITS+1)-1:0] credits
);

  localparam int CRED_W = $clog2(RES_CREDITS + 1);
  localparam int IDX_W  = $clog2(ENTRIES);

  mult_rs_entry_t             entries_q [ENTRIES];
  mult_rs_entry_t             entries_d [ENTRIES];
  issue_pkt_t                 issue_q;
  issue_pkt_t                 issue_d;
  logic [CRED_W-1:0]          credits_q;
  logic [CRED_W-1:0]          credits_d;

  mult_rs_entry_t             dispEntry;
  logic [IDX_W-1:0]           dispIdx;
  logic                       dispFound;
  logic                       dispFire;
  logic [ENTRIES-1:0]         readyVec;
  logic [ENTRIES-1:0]         grant;
  logic                       grantValid;
  logic                       issueFire;
  logic                       creditInc;
  logic [DEFAULT_TAG_W-1:0]   cdbTagW;

  assign cdbTagW = DEFAULT_TAG_W'(cdb_tag);

  // Find the lowest-index free entry; its existence is also disp_ready.
  always_comb begin
    dispIdx   = '0;
    dispFound = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!entries_q[i].valid && !dispFound) begin
        dispIdx   = IDX_W'(i);
        dispFound = 1'b1;
      end
    end
  end

  assign disp_ready = dispFound;
  assign dispFire   = disp_valid && dispFound && !flush;

  // Build the entry being dispatched, forwarding a same-cycle CDB result
  // into any operand that is still waiting on that tag.
  always_comb begin
    dispEntry.valid  = 1'b1;
    dispEntry.op1    = disp_op1;
    dispEntry.op2    = disp_op2;
    dispEntry.op1Rdy = disp_op1_rdy;
    dispEntry.op2Rdy = disp_op2_rdy;
    dispEntry.op1Tag = DEFAULT_TAG_W'(disp_op1_tag);
    dispEntry.op2Tag = DEFAULT_TAG_W'(disp_op2_tag);
    dispEntry.funct3 = disp_funct3;
    dispEntry.tag    = DEFAULT_TAG_W'(disp_tag);
    if (cdb_valid && !disp_op1_rdy && (dispEntry.op1Tag == cdbTagW)) begin
      dispEntry.op1    = cdb_data;
      dispEntry.op1Rdy = 1'b1;
    end
    if (cdb_valid && !disp_op2_rdy && (dispEntry.op2Tag == cdbTagW)) begin
      dispEntry.op2    = cdb_data;
      dispEntry.op2Rdy = 1'b1;
    end
  end

  // An entry may be picked once valid with both operands present, unless it
  // is the slot being overwritten by a dispatch this cycle.
  always_comb begin
    readyVec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      readyVec[i] = entries_q[i].valid && entries_q[i].op1Rdy &&
                    entries_q[i].op2Rdy &&
                    !(dispFire && (dispIdx == IDX_W'(i)));
    end
  end

`ifdef MULT_RS_AGE_SELECT_EN
  localparam int RANK_W = IDX_W;

  logic [ENTRIES-1:0][RANK_W-1:0] age_q;
  logic [ENTRIES-1:0][RANK_W-1:0] age_d;
  logic [RANK_W-1:0]              issuedRank;
  logic [RANK_W-1:0]              liveCount;

  mult_rs_select #(
    .ENTRIES (ENTRIES),
    .RANK_W  (RANK_W)
  ) u_select (
    .ready_i (readyVec),
    .age_i   (age_q),
    .grant_o (grant),
    .valid_o (grantValid)
  );

  // Rank 0 is the oldest. A new entry ranks behind every surviving entry;
  // when an entry issues, every younger entry moves one rank forward.
  always_comb begin
    issuedRank = '0;
    liveCount  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        issuedRank = issuedRank | age_q[i];
      end
      if (entries_q[i].valid && !(issueFire && grant[i])) begin
        liveCount = liveCount + RANK_W'(1);
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (issueFire && entries_q[i].valid && !grant[i] && (age_q[i] > issuedRank)) begin
        age_d[i] = age_q[i] - RANK_W'(1);
      end
      if (dispFire && (dispIdx == IDX_W'(i))) begin
        age_d[i] = liveCount;
      end
      if (flush) begin
        age_d[i] = '0;
      end
    end
  end

  // Age rank storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  mult_rs_select #(
    .ENTRIES (ENTRIES)
  ) u_select (
    .ready_i (readyVec),
    .grant_o (grant),
    .valid_o (grantValid)
  );
`endif

  assign issueFire = grantValid && (credits_q != '0) && !flush;

  // Next entry state: CDB capture, invalidate on issue, dispatch write,
  // and flush last so it overrides everything else.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid && cdb_valid) begin
        if (!entries_q[i].op1Rdy && (entries_q[i].op1Tag == cdbTagW)) begin
          entries_d[i].op1    = cdb_data;
          entries_d[i].op1Rdy = 1'b1;
        end
        if (!entries_q[i].op2Rdy && (entries_q[i].op2Tag == cdbTagW)) begin
          entries_d[i].op2    = cdb_data;
          entries_d[i].op2Rdy = 1'b1;
        end
      end
      if (issueFire && grant[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (dispFire && (dispIdx == IDX_W'(i))) begin
        entries_d[i] = dispEntry;
      end
      if (flush) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  // Load the issue slot from the granted entry, or an all-zero idle slot.
  always_comb begin
    issue_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (issueFire && grant[i]) begin
        issue_d = issueFromEntry(entries_q[i]);
      end
    end
  end

  // Credits drop on each issue and return on each pop; a pop with the
  // counter already full is ignored.
  always_comb begin
    creditInc = res_pop && (credits_q != CRED_W'(RES_CREDITS));
    credits_d = credits_q;
    case ({issueFire, creditInc})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // All registered state; flush is handled in the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      issue_q   <= '0;
      credits_q <= CRED_W'(RES_CREDITS);
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= entries_d[i];
      end
      issue_q   <= issue_d;
      credits_q <= credits_d;
    end
  end

  assign issue_en        = issue_q.en;
  assign issue_tag_valid = issue_q.tagValid;
  assign issue_op1       = issue_q.op1;
  assign issue_op2       = issue_q.op2;
  assign issue_funct3    = issue_q.funct3;
  assign issue_tag       = TAG_W'(issue_q.tag);
  assign credits         = credits_q;

  // A pop while every credit is already home means downstream lost track.
  resPopOverflowA: assert property (@(posedge clk) disable iff (rst)
    !(res_pop && (credits_q == CRED_W'(RES_CREDITS))));

endmodule

// File: tb/tb_mult_rs_ctrl.sv
// Self-checking bench for mult_rs_ctrl: directed scenarios plus a randomized
// single-op-in-flight run checked against a latency/credit model.
module tb_mult_rs_ctrl;

  localparam int ENTRIES     = 4;
  localparam int RES_CREDITS = 4;
  localparam int TAG_W       = 6;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [31:0]      disp_op1;
  logic [31:0]      disp_op2;
  logic             disp_op1_rdy;
  logic             disp_op2_rdy;
  logic [TAG_W-1:0] disp_op1_tag;
  logic [TAG_W-1:0] disp_op2_tag;
  logic [2:0]       disp_funct3;
  logic [TAG_W-1:0] disp_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_en;
  logic [31:0]      issue_op1;
  logic [31:0]      issue_op2;
  logic [2:0]       issue_funct3;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_tag_valid;
  logic             res_pop;
  logic [2:0]       credits;

  int assertCount = 0;
  int failCount   = 0;
  int expCredits  = RES_CREDITS;

  wire [74:0] issueVec = {issue_en, issue_tag_valid, issue_op1, issue_op2, issue_funct3, issue_tag};

  mult_rs_ctrl #(
    .ENTRIES     (ENTRIES),
    .RES_CREDITS (RES_CREDITS),
    .TAG_W       (TAG_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_op1        (disp_op1),
    .disp_op2        (disp_op2),
    .disp_op1_rdy    (disp_op1_rdy),
    .disp_op2_rdy    (disp_op2_rdy),
    .disp_op1_tag    (disp_op1_tag),
    .disp_op2_tag    (disp_op2_tag),
    .disp_funct3     (disp_funct3),
    .disp_tag        (disp_tag),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .issue_en        (issue_en),
    .issue_op1       (issue_op1),
    .issue_op2       (issue_op2),
    .issue_funct3    (issue_funct3),
    .issue_tag       (issue_tag),
    .issue_tag_valid (issue_tag_valid),
    .res_pop         (res_pop),
    .credits         (credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush        = 1'b0;
    disp_valid   = 1'b0;
    disp_op1     = '0;
    disp_op2     = '0;
    disp_op1_rdy = 1'b0;
    disp_op2_rdy = 1'b0;
    disp_op1_tag = '0;
    disp_op2_tag = '0;
    disp_funct3  = '0;
    disp_tag     = '0;
    cdb_valid    = 1'b0;
    cdb_tag      = '0;
    cdb_data     = '0;
    res_pop      = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] o1, input logic r1, input logic [5:0] t1,
                          input logic [31:0] o2, input logic r2, input logic [5:0] t2,
                          input logic [2:0] f3, input logic [5:0] tg);
    disp_valid   = 1'b1;
    disp_op1     = o1;
    disp_op1_rdy = r1;
    disp_op1_tag = t1;
    disp_op2     = o2;
    disp_op2_rdy = r2;
    disp_op2_tag = t2;
    disp_funct3  = f3;
    disp_tag     = tg;
  endtask

  // Hand credits back one per cycle until the model counter is full.
  task automatic restoreCredits();
    while (expCredits < RES_CREDITS) begin
      res_pop = 1'b1;
      tick();
      expCredits++;
    end
    res_pop = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    expCredits = RES_CREDITS;
    assertCount++;
    if (issueVec !== 75'd0) begin
      failCount++;
      $display("[TB] FAIL reset_issue: got %h expected %h", issueVec, 75'd0);
    end
    assertCount++;
    if (credits !== 3'd4) begin
      failCount++;
      $display("[TB] FAIL reset_credits: got %0d expected %0d", credits, 4);
    end
    assertCount++;
    if (disp_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_disp_ready: got %0b expected 1", disp_ready);
    end
  endtask

  task automatic test_basic();
    dispatch(32'd7, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 3'd0, 6'd5);
    tick();
    idleInputs();
    assertCount++;
    if (issue_en !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_early: got %0b expected 0", issue_en);
    end
    tick();
    expCredits--;
    assertCount++;
    if (issueVec !== {1'b1, 1'b1, 32'd7, 32'd6, 3'd0, 6'd5}) begin
      failCount++;
      $display("[TB] FAIL basic_issue: got %h expected %h", issueVec, {1'b1, 1'b1, 32'd7, 32'd6, 3'd0, 6'd5});
    end
    assertCount++;
    if (credits !== 3'(expCredits)) begin
      failCount++;
      $display("[TB] FAIL basic_credits: got %0d expected %0d", credits, expCredits);
    end
    tick();
    assertCount++;
    if (issueVec !== 75'd0) begin
      failCount++;
      $display("[TB] FAIL basic_idle_slot: got %h expected %h", issueVec, 75'd0);
    end
    restoreCredits();
  endtask

  task automatic test_cdb_wakeup();
    dispatch(32'h11, 1'b1, 6'd0, 32'h0, 1'b0, 6'd9, 3'd1, 6'd12);
    tick();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_data  = 32'h10;
      end
      tick();
      assertCount++;
      if (issue_en !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL wakeup_early_%0d: got %0b expected 0", k, issue_en);
      end
    end
    idleInputs();
    tick();
    expCredits--;
    assertCount++;
    if (issueVec !== {1'b1, 1'b1, 32'h11, 32'h10, 3'd1, 6'd12}) begin
      failCount++;
      $display("[TB] FAIL wakeup_issue: got %h expected %h", issueVec, {1'b1, 1'b1, 32'h11, 32'h10, 3'd1, 6'd12});
    end
    restoreCredits();
  endtask

  task automatic test_bypass();
    dispatch(32'h0, 1'b0, 6'd3, 32'h22, 1'b1, 6'd0, 3'd2, 6'd7);
    cdb_valid = 1'b1;
    cdb_tag   = 6'd3;
    cdb_data  = 32'hAB;
    tick();
    idleInputs();
    assertCount++;
    if (issue_en !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bypass_early: got %0b expected 0", issue_en);
    end
    tick();
    expCredits--;
    assertCount++;
    if (issueVec !== {1'b1, 1'b1, 32'hAB, 32'h22, 3'd2, 6'd7}) begin
      failCount++;
      $display("[TB] FAIL bypass_issue: got %h expected %h", issueVec, {1'b1, 1'b1, 32'hAB, 32'h22, 3'd2, 6'd7});
    end
    restoreCredits();
  endtask

  // Four waiting entries fill the station; a fifth dispatch is refused.
  task automatic test_full();
    for (int i = 0; i < ENTRIES; i++) begin
      dispatch(32'h0, 1'b0, 6'd60, 32'(i), 1'b1, 6'd0, 3'd0, 6'(50 + i));
      tick();
    end
    assertCount++;
    if (disp_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL full_disp_ready: got %0b expected 0", disp_ready);
    end
    dispatch(32'h1, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 3'd0, 6'd54);
    tick();
    idleInputs();
    cdb_valid = 1'b1;
    cdb_tag   = 6'd60;
    cdb_data  = 32'h99;
    tick();
    idleInputs();
    for (int k = 0; k < ENTRIES; k++) begin
      tick();
      expCredits--;
      assertCount++;
      if (issueVec !== {1'b1, 1'b1, 32'h99, 32'(k), 3'd0, 6'(50 + k)}) begin
        failCount++;
        $display("[TB] FAIL full_issue_%0d: got %h expected %h", k, issueVec, {1'b1, 1'b1, 32'h99, 32'(k), 3'd0, 6'(50 + k)});
      end
    end
    tick();
    assertCount++;
    if ((issue_en !== 1'b0) || (disp_ready !== 1'b1)) begin
      failCount++;
      $display("[TB] FAIL full_drained: got en=%0b ready=%0b expected en=0 ready=1", issue_en, disp_ready);
    end
    restoreCredits();
  endtask

  task automatic test_credit_stall();
    for (int i = 0; i < 4; i++) begin
      dispatch(32'(i + 1), 1'b1, 6'd0, 32'(i * 3), 1'b1, 6'd0, 3'd1, 6'(20 + i));
      tick();
      if (i > 0) begin
        expCredits--;
        assertCount++;
        if ((issue_en !== 1'b1) || (issue_tag !== 6'(20 + i - 1))) begin
          failCount++;
          $display("[TB] FAIL stall_issue_%0d: got en=%0b tag=%0d expected en=1 tag=%0d", i - 1, issue_en, issue_tag, 20 + i - 1);
        end
      end
    end
    idleInputs();
    tick();
    expCredits--;
    assertCount++;
    if ((issue_en !== 1'b1) || (issue_tag !== 6'd23)) begin
      failCount++;
      $display("[TB] FAIL stall_issue_3: got en=%0b tag=%0d expected en=1 tag=23", issue_en, issue_tag);
    end
    dispatch(32'h5, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 3'd0, 6'd24);
    tick();
    idleInputs();
    tick();
    tick();
    assertCount++;
    if ((issue_en !== 1'b0) || (credits !== 3'd0)) begin
      failCount++;
      $display("[TB] FAIL stall_hold: got en=%0b credits=%0d expected en=0 credits=0", issue_en, credits);
    end
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    expCredits++;
    assertCount++;
    if ((issue_en !== 1'b0) || (credits !== 3'd1)) begin
      failCount++;
      $display("[TB] FAIL stall_pop: got en=%0b credits=%0d expected en=0 credits=1", issue_en, credits);
    end
    tick();
    expCredits--;
    assertCount++;
    if ((issue_en !== 1'b1) || (issue_tag !== 6'd24) || (credits !== 3'd0)) begin
      failCount++;
      $display("[TB] FAIL stall_resume: got en=%0b tag=%0d credits=%0d expected en=1 tag=24 credits=0", issue_en, issue_tag, credits);
    end
    restoreCredits();
  endtask

  // Older entry A lands in slot 2, younger B in slot 0; both wake together.
  task automatic test_age_select();
    logic [5:0] firstTag;
    logic [5:0] secondTag;
`ifdef MULT_RS_AGE_SELECT_EN
    firstTag  = 6'd3;
    secondTag = 6'd4;
`else
    firstTag  = 6'd4;
    secondTag = 6'd3;
`endif
    dispatch(32'h0, 1'b0, 6'd31, 32'h1, 1'b1, 6'd0, 3'd0, 6'd1);
    tick();
    dispatch(32'h0, 1'b0, 6'd30, 32'h2, 1'b1, 6'd0, 3'd0, 6'd2);
    tick();
    dispatch(32'h0, 1'b0, 6'd20, 32'h3, 1'b1, 6'd0, 3'd3, 6'd3);
    tick();
    idleInputs();
    cdb_valid = 1'b1;
    cdb_tag   = 6'd31;
    cdb_data  = 32'h5;
    tick();
    idleInputs();
    tick();
    expCredits--;
    assertCount++;
    if ((issue_en !== 1'b1) || (issue_tag !== 6'd1)) begin
      failCount++;
      $display("[TB] FAIL age_free_slot0: got en=%0b tag=%0d expected en=1 tag=1", issue_en, issue_tag);
    end
    tick();
    dispatch(32'h0, 1'b0, 6'd20, 32'h4, 1'b1, 6'd0, 3'd4, 6'd4);
    tick();
    idleInputs();
    cdb_valid = 1'b1;
    cdb_tag   = 6'd20;
    cdb_data  = 32'h77;
    tick();
    idleInputs();
    tick();
    expCredits--;
    assertCount++;
    if ((issue_en !== 1'b1) || (issue_tag !== firstTag) || (issue_op1 !== 32'h77)) begin
      failCount++;
      $display("[TB] FAIL age_first: got en=%0b tag=%0d op1=%h expected en=1 tag=%0d op1=77", issue_en, issue_tag, issue_op1, firstTag);
    end
    tick();
    expCredits--;
    assertCount++;
    if ((issue_en !== 1'b1) || (issue_tag !== secondTag) || (issue_op1 !== 32'h77)) begin
      failCount++;
      $display("[TB] FAIL age_second: got en=%0b tag=%0d op1=%h expected en=1 tag=%0d op1=77", issue_en, issue_tag, issue_op1, secondTag);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    restoreCredits();
  endtask

  task automatic test_flush();
    dispatch(32'h0, 1'b0, 6'd40, 32'h1, 1'b1, 6'd0, 3'd0, 6'd10);
    tick();
    dispatch(32'h1, 1'b1, 6'd0, 32'h0, 1'b0, 6'd41, 3'd0, 6'd11);
    tick();
    dispatch(32'h2, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 3'd0, 6'd12);
    tick();
    dispatch(32'h4, 1'b1, 6'd0, 32'h4, 1'b1, 6'd0, 3'd0, 6'd13);
    flush = 1'b1;
    tick();
    idleInputs();
    assertCount++;
    if ((issueVec !== 75'd0) || (disp_ready !== 1'b1) || (credits !== 3'(expCredits))) begin
      failCount++;
      $display("[TB] FAIL flush_state: got issue=%h ready=%0b credits=%0d expected issue=0 ready=1 credits=%0d", issueVec, disp_ready, credits, expCredits);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < 2) begin
        cdb_valid = 1'b1;
        cdb_tag   = 6'(40 + k);
        cdb_data  = 32'hF0;
      end else begin
        cdb_valid = 1'b0;
      end
      tick();
      assertCount++;
      if (issue_en !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL flush_empty_%0d: got %0b expected 0", k, issue_en);
      end
    end
    idleInputs();
  endtask

  task automatic test_reset_mid();
    dispatch(32'h8, 1'b1, 6'd0, 32'h9, 1'b1, 6'd0, 3'd0, 6'd15);
    tick();
    dispatch(32'hA, 1'b1, 6'd0, 32'hB, 1'b1, 6'd0, 3'd0, 6'd16);
    tick();
    idleInputs();
    assertCount++;
    if ((issue_en !== 1'b1) || (issue_tag !== 6'd15)) begin
      failCount++;
      $display("[TB] FAIL rstmid_pre: got en=%0b tag=%0d expected en=1 tag=15", issue_en, issue_tag);
    end
    #2;
    rst = 1'b1;
    #1;
    assertCount++;
    if ((issueVec !== 75'd0) || (credits !== 3'd4) || (disp_ready !== 1'b1)) begin
      failCount++;
      $display("[TB] FAIL rstmid_clear: got issue=%h credits=%0d ready=%0b expected issue=0 credits=4 ready=1", issueVec, credits, disp_ready);
    end
    #2;
    rst = 1'b0;
    expCredits = RES_CREDITS;
    for (int k = 0; k < 2; k++) begin
      tick();
      assertCount++;
      if (issue_en !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL rstmid_no_issue_%0d: got %0b expected 0", k, issue_en);
      end
    end
  endtask

  // One op in flight at a time; the model predicts the issue cycle from the
  // operand-arrival rule and tracks credits as a plain counter.
  task automatic test_random();
    logic [31:0] rOp1;
    logic [31:0] rOp2;
    logic [31:0] rData;
    logic [2:0]  rF3;
    logic [5:0]  rTag;
    logic [5:0]  rPend;
    int          mode;
    int          delay;
    logic        pop;
    for (int n = 0; n < 24; n++) begin
      rOp1  = $urandom;
      rOp2  = $urandom;
      rData = $urandom;
      rF3   = 3'($urandom_range(0, 7));
      rTag  = 6'($urandom_range(0, 63));
      rPend = 6'($urandom_range(0, 63));
      mode  = $urandom_range(0, 2);
      delay = $urandom_range(1, 3);
      if (mode == 0) begin
        dispatch(rOp1, 1'b1, 6'd0, rOp2, 1'b1, 6'd0, rF3, rTag);
        tick();
        idleInputs();
      end else if (mode == 1) begin
        dispatch(rOp1, 1'b1, 6'd0, 32'hDEAD, 1'b0, rPend, rF3, rTag);
        tick();
        idleInputs();
        for (int k = 0; k < delay; k++) begin
          cdb_valid = 1'b1;
          cdb_tag   = (k == delay - 1) ? rPend : (rPend ^ 6'h1);
          cdb_data  = (k == delay - 1) ? rData : $urandom;
          tick();
          if (k != delay - 1) begin
            assertCount++;
            if (issue_en !== 1'b0) begin
              failCount++;
              $display("[TB] FAIL rand_wait_%0d_%0d: got %0b expected 0", n, k, issue_en);
            end
          end
        end
        idleInputs();
        rOp2 = rData;
      end else begin
        dispatch(32'hBEEF, 1'b0, rPend, rOp2, 1'b1, 6'd0, rF3, rTag);
        cdb_valid = 1'b1;
        cdb_tag   = rPend;
        cdb_data  = rData;
        tick();
        idleInputs();
        rOp1 = rData;
      end
      assertCount++;
      if (issue_en !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL rand_early_%0d: got %0b expected 0", n, issue_en);
      end
      tick();
      expCredits--;
      assertCount++;
      if ((issueVec !== {1'b1, 1'b1, rOp1, rOp2, rF3, rTag}) || (credits !== 3'(expCredits))) begin
        failCount++;
        $display("[TB] FAIL rand_issue_%0d: got %h credits=%0d expected %h credits=%0d", n, issueVec, credits, {1'b1, 1'b1, rOp1, rOp2, rF3, rTag}, expCredits);
      end
      pop = (expCredits == 0) || ((expCredits < RES_CREDITS) && ($urandom_range(0, 1) == 1));
      res_pop = pop;
      tick();
      res_pop = 1'b0;
      if (pop) begin
        expCredits++;
      end
      assertCount++;
      if (credits !== 3'(expCredits)) begin
        failCount++;
        $display("[TB] FAIL rand_credits_%0d: got %0d expected %0d", n, credits, expCredits);
      end
    end
    restoreCredits();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_credit_stall();
    test_age_select();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
